// File: rtl/ras_ctrl.sv
// ras_ctrl: RISC-V call/return hint decoder driving a return-address lifo; RAS_CTRL_STATS_EN adds ovf/unf counters.
// Latency: push/pop/data combinational in the accept cycle, prediction 1 cycle after a pop; pop-then-push spans 2 cycles.
// Backpressure: inst_ready_o drops only in SWAP; a full lifo never stalls (the push is dropped downstream).
module ras_ctrl #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            inst_valid_i,
   output logic            inst_ready_o,
   input  logic [ILEN-1:0] inst_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            pred_valid_o,
   output logic [XLEN-1:0] pred_target_o,
   output logic            lifo_push_o,
   output logic            lifo_pop_o,
   output logic [XLEN-1:0] lifo_data_o,
   input  logic [XLEN-1:0] lifo_data_i,
   input  logic            lifo_full_i,
`ifdef RAS_CTRL_STATS_EN
   output logic [15:0]     ovf_cnt_o,
   output logic [15:0]     unf_cnt_o,
`endif
   input  logic            lifo_empty_i
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SWAP = 1'b1;

   logic [0:0]      r_state;
   logic [XLEN-1:0] r_link;
   logic            r_pred_valid;
   logic [XLEN-1:0] r_pred_target;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic            w_is_jal;
   logic            w_is_jalr;
   logic            w_rd_link;
   logic            w_rs1_link;
   logic            w_cls_push;
   logic            w_cls_pop;
   logic            w_cls_swap;
   logic            w_accept;
   logic [XLEN-1:0] w_pc_inc;
   logic            w_push;
   logic            w_pop;
   logic [XLEN-1:0] w_data;
   logic            w_link_ld;
   logic [0:0]      w_state_nxt;
   logic            w_unused;

   assign w_opcode   = inst_i[6:0];
   assign w_rd       = inst_i[11:7];
   assign w_funct3   = inst_i[14:12];
   assign w_rs1      = inst_i[19:15];
   assign w_unused   = ^inst_i[ILEN-1:20];

   assign w_is_jal   = (w_opcode == 7'b1101111);
   assign w_is_jalr  = (w_opcode == 7'b1100111) && (w_funct3 == 3'b000);
   assign w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
   assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);

   // rd==rs1 with both links is a plain call; differing links is a coroutine swap
   assign w_cls_push = (w_is_jal && w_rd_link) ||
                       (w_is_jalr && w_rd_link && (!w_rs1_link || (w_rd == w_rs1)));
   assign w_cls_pop  = w_is_jalr && !w_rd_link && w_rs1_link;
   assign w_cls_swap = w_is_jalr && w_rd_link && w_rs1_link && (w_rd != w_rs1);

   assign inst_ready_o = (r_state == ST_IDLE);
   assign w_accept     = inst_valid_i && inst_ready_o && !flush_i && !rst_i;
   assign w_pc_inc     = pc_i + XLEN'(4);

   always_comb begin
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_data      = '0;
      w_link_ld   = 1'b0;
      w_state_nxt = r_state;
      if (r_state == ST_SWAP) begin
         w_state_nxt = ST_IDLE;
         if (!flush_i) begin
            w_push = 1'b1;
            w_data = r_link;
         end
      end else if (w_accept) begin
         // a swap against an empty lifo degenerates to a single push
         if (w_cls_push || (w_cls_swap && lifo_empty_i)) begin
            w_push = 1'b1;
            w_data = w_pc_inc;
         end else if ((w_cls_pop || w_cls_swap) && !lifo_empty_i) begin
            w_pop = 1'b1;
            if (w_cls_swap) begin
               w_link_ld   = 1'b1;
               w_state_nxt = ST_SWAP;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= ST_IDLE;
         r_link        <= '0;
         r_pred_valid  <= 1'b0;
         r_pred_target <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pred_valid <= w_pop;
         if (w_link_ld) r_link <= w_pc_inc;
         if (w_pop) r_pred_target <= lifo_data_i;
      end
   end

   assign lifo_push_o   = w_push;
   assign lifo_pop_o    = w_pop;
   assign lifo_data_o   = w_data;
   assign pred_valid_o  = r_pred_valid;
   assign pred_target_o = r_pred_target;

`ifdef RAS_CTRL_STATS_EN
   logic [15:0] r_ovf_cnt;
   logic [15:0] r_unf_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ovf_cnt <= '0;
         r_unf_cnt <= '0;
      end else begin
         if (w_push && lifo_full_i && (r_ovf_cnt != 16'hFFFF))
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
         if (w_accept && (w_cls_pop || w_cls_swap) && lifo_empty_i && (r_unf_cnt != 16'hFFFF))
            r_unf_cnt <= r_unf_cnt + 16'd1;
      end
   end

   assign ovf_cnt_o = r_ovf_cnt;
   assign unf_cnt_o = r_unf_cnt;
`endif

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Return-address-stack controller in the fetch/decode front end.
- Decodes each accepted instruction for RISC-V call/return hints (JAL/JALR with link registers x1/x5).
- Drives push/pop/data on the downstream lifo, which holds return addresses, and emits a registered return-target prediction.
- Splits the pop-then-push (coroutine) case into two cycles, because the lifo cannot push and pop in the same cycle.

Parameters:
- XLEN, 64, width of PC and return address.
- ILEN, 32, instruction width; only uncompressed encodings are decoded.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush; aborts any pending sequence.
- inst_valid_i  in  1  instruction/PC valid.
- inst_ready_o  out  1  block can accept an instruction.
- inst_i  in  ILEN  instruction word.
- pc_i  in  XLEN  PC of inst_i.
- pred_valid_o  out  1  one-cycle pulse: pred_target_o is valid.
- pred_target_o  out  XLEN  predicted return target.
- lifo_push_o  out  1  push to lifo.
- lifo_pop_o  out  1  pop from lifo.
- lifo_data_o  out  XLEN  return address to push.
- lifo_data_i  in  XLEN  lifo top of stack (combinational).
- lifo_full_i  in  1  lifo full.
- lifo_empty_i  in  1  lifo empty.

Behaviour:
- Reset: state=IDLE; inst_ready_o=1; pred_valid_o=0; pred_target_o=0; lifo_push_o=0; lifo_pop_o=0; lifo_data_o=0; link register=0.
- Accept: inst_valid_i & inst_ready_o & !flush_i. inst_ready_o = (state==IDLE).
- Decode:
  - JAL: opcode 1101111.
  - JALR: opcode 1100111 with funct3=000.
  - link(r) = (r==1 || r==5).
  - Any other encoding: no action.
- Action table (RISC-V hint table):
  - JAL, link(rd): push.
  - JAL, !link(rd): none.
  - JALR, !link(rd), !link(rs1): none.
  - JALR, !link(rd), link(rs1): pop.
  - JALR, link(rd), !link(rs1): push.
  - JALR, link(rd), link(rs1), rd==rs1: push.
  - JALR, link(rd), link(rs1), rd!=rs1: pop-then-push.
- Push data: lifo_data_o = pc_i + 4, truncated to XLEN (wraps at 2^XLEN).
- lifo_push_o, lifo_pop_o and lifo_data_o are combinational in the accept cycle. They are never both high.
- Push with lifo_full_i=1: lifo_push_o still asserted. The lifo drops it; no retry.
- Pop:
  - lifo_pop_o = accept & pop-class & !lifo_empty_i.
  - On a non-empty pop, lifo_data_i is registered into pred_target_o and pred_valid_o pulses high the next cycle (latency 1).
  - Pop on empty: no pop, pred_valid_o stays 0.
- FSM states IDLE and SWAP:
  - IDLE, accept of pop-then-push with !lifo_empty_i: assert lifo_pop_o, register pc_i+4 into the link register, go to SWAP.
  - IDLE, pop-then-push with lifo_empty_i: handled as push only in the same cycle, stay in IDLE. pred_valid_o stays 0.
  - SWAP: inst_ready_o=0. Assert lifo_push_o with lifo_data_o = link register, then go to IDLE. The prediction from the pop pulses in this cycle.
  - SWAP with flush_i=1: no push, go to IDLE. The pred_valid_o pulse still occurs.
- flush_i in IDLE: blocks acceptance. No push/pop, no prediction.
- rst_i mid-SWAP: immediately IDLE, pending push lost, outputs at reset values.
- Back-to-back: a new accept is possible every IDLE cycle. Two consecutive pops give two consecutive pred_valid_o pulses.

Optional Feature:
- Macro: RAS_CTRL_STATS_EN.
- Defined adds two outputs, each reset to 0 and saturating at 0xFFFF:
  - ovf_cnt_o [15:0]: increments on any push issued while lifo_full_i=1.
  - unf_cnt_o [15:0]: increments on any accepted pop-class instruction while lifo_empty_i=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then JAL x1 (0x008000EF) at pc=0x1000 → lifo_push_o=1 and lifo_data_o=0x1004 in the accept cycle; pred_valid_o=0.
- lifo top=0x1004, JALR x0,0(x1) (0x00008067) → lifo_pop_o=1; next cycle pred_valid_o=1 and pred_target_o=0x1004.
- lifo top=0x2004, JALR x5,0(x1) at pc=0x3000:
  - cycle0: lifo_pop_o=1, inst_ready_o stays 1.
  - cycle1: inst_ready_o=0, lifo_push_o=1, lifo_data_o=0x3004, pred_valid_o=1, pred_target_o=0x2004.
  - cycle2: inst_ready_o=1.
- Same sequence with flush_i=1 in cycle1 → no push, inst_ready_o=1 in cycle2. Repeat with rst_i pulsed in cycle1 → all outputs at reset values.
- Pop on lifo_empty_i=1, and JAL x1 at pc=0xFFFF_FFFF_FFFF_FFFC:
  - empty pop: no lifo_pop_o, no prediction.
  - JAL: lifo_data_o=0x0 (wrap).
  - With RAS_CTRL_STATS_EN: unf_cnt_o=1.
- With RAS_CTRL_STATS_EN: 3 pushes with lifo_full_i=1 → ovf_cnt_o=3. Separately, force the counter to 0xFFFF and push once more while full → ovf_cnt_o stays 0xFFFF.
